// File: rtl/lcs_poller.sv
// LCS link initiator: strobes req per word, samples dataRx into a frame
// buffer write port and republishes the temperature slot with a channel tag.
module lcs_poller #(
    parameter int WORDS      = 128,
    parameter int REQ_HIGH   = 8,
    parameter int SAMPLE_DLY = 6,
    parameter int GAP        = 8,
    parameter int TEMP_IDX   = 121
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dataRx,
    output logic       req,
    output logic       busy,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       temp_valid,
    output logic [7:0] temp_data,
    output logic [4:0] temp_ch,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [7:0] T_SMP     = 8'(SAMPLE_DLY);
    localparam logic [7:0] T_REQ_END = 8'(REQ_HIGH - 1);
    localparam logic [7:0] T_GAP_END = 8'(GAP - 1);
    localparam logic [6:0] IDX_LAST  = 7'(WORDS - 1);
    localparam logic [6:0] IDX_TEMP  = 7'(TEMP_IDX);
    localparam bit         TEMP_ON   = (TEMP_IDX < WORDS);

    state_e     state_q, state_d;
    logic [7:0] t_q, t_d;
    logic [6:0] idx_q, idx_d;

    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       wr_en_q, wr_en_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       temp_valid_q, temp_valid_d;
    logic [7:0] temp_data_q, temp_data_d;
    logic [4:0] temp_ch_q, temp_ch_d;
    logic       frame_done_q, frame_done_d;

    logic       sample;

    assign sample = (state_q == S_REQ) && (t_q == T_SMP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            idx_q        <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            temp_valid_q <= 1'b0;
            temp_data_q  <= '0;
            temp_ch_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            idx_q        <= idx_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            temp_valid_q <= temp_valid_d;
            temp_data_q  <= temp_data_d;
            temp_ch_q    <= temp_ch_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q + 8'd1;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = '0;
                end
            end
            S_REQ: begin
                if (t_q == T_REQ_END) begin
                    state_d = S_GAP;
                    t_d     = '0;
                end
            end
            S_GAP: begin
                if (t_q == T_GAP_END) begin
                    t_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        idx_d   = idx_q + 7'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Strobes are registered copies of the next state, so they line up
    // with the state register rather than trailing it by a cycle.
    always_comb begin
        req_d        = (state_d == S_REQ);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        wr_en_d      = sample;
        wr_addr_d    = sample ? idx_q : wr_addr_q;
        wr_data_d    = sample ? dataRx : wr_data_q;
        temp_valid_d = sample && TEMP_ON && (idx_q == IDX_TEMP);
        temp_data_d  = temp_valid_d ? dataRx : temp_data_q;
        temp_ch_d    = (state_q == S_DONE) ? temp_ch_q + 5'd1 : temp_ch_q;
    end

    assign req        = req_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign temp_valid = temp_valid_q;
    assign temp_data  = temp_data_q;
    assign temp_ch    = temp_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcs_poller.sv
// Bench for lcs_poller: three instances (default, WORDS=4, WORDS=2/TEMP_IDX=1)
// compared each cycle against a frame-timing model built from cycle arithmetic.
module tb_lcs_poller;

    localparam int RH = 8;
    localparam int SD = 6;
    localparam int GP = 8;
    localparam int P  = RH + GP;
    localparam int NI = 3;

    int words[NI] = '{128, 4, 2};
    int tidx[NI]  = '{121, 121, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start[NI];
    logic [7:0] rx[NI];

    logic       req_o[NI];
    logic       busy_o[NI];
    logic       we_o[NI];
    logic [6:0] wa_o[NI];
    logic [7:0] wd_o[NI];
    logic       tv_o[NI];
    logic [7:0] td_o[NI];
    logic [4:0] ch_o[NI];
    logic       fd_o[NI];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit         act[NI];
    int         c0[NI];
    int         nst[NI];
    logic [7:0] prx[NI];
    logic [6:0] e_wa[NI];
    logic [7:0] e_wd[NI];
    logic [7:0] e_td[NI];
    logic [4:0] e_ch[NI];

    int fd_cnt[NI], we_cnt[NI], tv_cnt[NI], req_cnt[NI], fd_cyc[NI];
    int first_wa[NI];
    bit got_wa[NI];
    int w4_wa[$], w4_wd[$], w2_ch[$];
    int def_td, def_tc;

    lcs_poller #(.WORDS(128), .TEMP_IDX(121)) u_def (
        .clk(clk), .rst(rst), .start(start[0]), .dataRx(rx[0]),
        .req(req_o[0]), .busy(busy_o[0]), .wr_en(we_o[0]),
        .wr_addr(wa_o[0]), .wr_data(wd_o[0]), .temp_valid(tv_o[0]),
        .temp_data(td_o[0]), .temp_ch(ch_o[0]), .frame_done(fd_o[0])
    );

    lcs_poller #(.WORDS(4), .TEMP_IDX(121)) u_w4 (
        .clk(clk), .rst(rst), .start(start[1]), .dataRx(rx[1]),
        .req(req_o[1]), .busy(busy_o[1]), .wr_en(we_o[1]),
        .wr_addr(wa_o[1]), .wr_data(wd_o[1]), .temp_valid(tv_o[1]),
        .temp_data(td_o[1]), .temp_ch(ch_o[1]), .frame_done(fd_o[1])
    );

    lcs_poller #(.WORDS(2), .TEMP_IDX(1)) u_w2 (
        .clk(clk), .rst(rst), .start(start[2]), .dataRx(rx[2]),
        .req(req_o[2]), .busy(busy_o[2]), .wr_en(we_o[2]),
        .wr_addr(wa_o[2]), .wr_data(wd_o[2]), .temp_valid(tv_o[2]),
        .temp_data(td_o[2]), .temp_ch(ch_o[2]), .frame_done(fd_o[2])
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < NI; i++) begin
            fd_cnt[i]   = 0;
            we_cnt[i]   = 0;
            tv_cnt[i]   = 0;
            req_cnt[i]  = 0;
            fd_cyc[i]   = -1;
            first_wa[i] = -1;
            got_wa[i]   = 1'b0;
        end
        w4_wa.delete();
        w4_wd.delete();
        w2_ch.delete();
    endtask

    // Model + compare: outputs seen in cycle n follow from the start cycle C
    // alone: rel = n-C-1, word = rel/P, phase = rel%P.
    always @(negedge clk) begin
        int rel, k, ph;
        bit e_req, e_busy, e_we, e_tv, e_fd;
        logic [32:0] got, expv;
        for (int i = 0; i < NI; i++) begin
            e_req = 0; e_busy = 0; e_we = 0; e_tv = 0; e_fd = 0;
            rel = 0;
            if (!rst) begin
                act[i]  = 1'b0;
                e_wa[i] = '0;
                e_wd[i] = '0;
                e_td[i] = '0;
                e_ch[i] = '0;
            end else if (act[i]) begin
                rel    = cyc - c0[i] - 1;
                k      = rel / P;
                ph     = rel % P;
                e_busy = 1;
                e_req  = (k < words[i]) && (ph < RH);
                e_we   = (k < words[i]) && (ph == SD + 1);
                e_fd   = (rel == words[i] * P);
                if (e_we) begin
                    e_wa[i] = 7'(k);
                    e_wd[i] = prx[i];
                    if (k == tidx[i]) begin
                        e_tv    = 1;
                        e_td[i] = prx[i];
                    end
                end
            end
            got  = {req_o[i], busy_o[i], we_o[i], wa_o[i], wd_o[i],
                    tv_o[i], td_o[i], ch_o[i], fd_o[i]};
            expv = {e_req, e_busy, e_we, e_wa[i], e_wd[i],
                    e_tv, e_td[i], e_ch[i], e_fd};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL outputs inst%0d cyc%0d: got %h expected %h",
                         i, cyc, got, expv);
            end
            if (rst) begin
                if (we_o[i]) begin
                    we_cnt[i]++;
                    if (!got_wa[i]) begin
                        got_wa[i]   = 1'b1;
                        first_wa[i] = int'(wa_o[i]);
                    end
                    if (i == 1) begin
                        w4_wa.push_back(int'(wa_o[i]));
                        w4_wd.push_back(int'(wd_o[i]));
                    end
                end
                if (tv_o[i]) begin
                    tv_cnt[i]++;
                    if (i == 2) w2_ch.push_back(int'(ch_o[i]));
                    if (i == 0) begin
                        def_td = int'(td_o[i]);
                        def_tc = int'(ch_o[i]);
                    end
                end
                if (req_o[i]) req_cnt[i]++;
                if (fd_o[i]) begin
                    fd_cnt[i]++;
                    if (fd_cyc[i] < 0) fd_cyc[i] = cyc;
                end
                if (act[i] && rel == words[i] * P) begin
                    act[i]  = 1'b0;
                    e_ch[i] = e_ch[i] + 5'd1;
                end else if (!act[i] && start[i]) begin
                    act[i] = 1'b1;
                    c0[i]  = cyc;
                    nst[i]++;
                end
            end
            prx[i] = rx[i];
        end
        cyc++;
    end

    // Answer bytes: 0x10+word on the WORDS=4 unit, 0xA5 only in word 121
    // on the default unit, random elsewhere.
    always @(posedge clk) begin
        int k;
        logic [7:0] r;
        #1;
        for (int i = 0; i < NI; i++) begin
            k = act[i] ? (cyc - c0[i] - 1) / P : -1;
            r = 8'($urandom_range(0, 255));
            if (i == 0) begin
                if (k == 121) rx[i] = 8'hA5;
                else rx[i] = (r == 8'hA5) ? 8'h5A : r;
            end else if (i == 1) begin
                rx[i] = (k >= 0) ? 8'(16 + k) : r;
            end else begin
                rx[i] = r;
            end
        end
    end

    initial begin
        int s0, sr, anyout;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b1;
            rx[i]    = '0;
            nst[i]   = 0;
            act[i]   = 1'b0;
        end
        clr();
        #1 rst = 1'b0;
        step(5);
        anyout = 0;
        for (int i = 0; i < NI; i++)
            anyout += int'(req_o[i]) + int'(busy_o[i]) + int'(we_o[i]) +
                      int'(wa_o[i]) + int'(wd_o[i]) + int'(tv_o[i]) +
                      int'(td_o[i]) + int'(ch_o[i]) + int'(fd_o[i]);
        chk("reset_outputs_zero", anyout, 0);
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        step(1);
        rst = 1'b1;
        step(6);
        chk("idle_no_busy", int'(busy_o[0]) + int'(busy_o[1]) + int'(busy_o[2]), 0);

        clr();
        s0 = cyc;
        for (int i = 0; i < NI; i++) start[i] = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            step(1);
            start[0] = (cyc == s0 + 700);
            start[1] = (cyc == s0 + 30);
            if (nst[2] >= 33) start[2] = 1'b0;
        end
        chk("w4_frame_done_cycle", fd_cyc[1] - s0, 65);
        chk("w4_frame_count", fd_cnt[1], 1);
        chk("w4_wr_en_count", we_cnt[1], 4);
        for (int j = 0; j < 4 && j < w4_wa.size(); j++) begin
            chk("w4_wr_addr", w4_wa[j], j);
            chk("w4_wr_data", w4_wd[j], 16 + j);
        end
        chk("w4_req_cycles", req_cnt[1], 32);
        chk("w4_no_temp_valid", tv_cnt[1], 0);
        chk("w4_temp_ch_after", int'(ch_o[1]), 1);
        chk("def_frame_count", fd_cnt[0], 1);
        chk("def_wr_en_count", we_cnt[0], 128);
        chk("def_temp_valid_count", tv_cnt[0], 1);
        chk("def_temp_data", def_td, 165);
        chk("def_temp_ch_at_valid", def_tc, 0);
        chk("def_temp_ch_after", int'(ch_o[0]), 1);
        chk("w2_frame_count", fd_cnt[2], 33);
        chk("w2_temp_valid_count", tv_cnt[2], 33);
        for (int j = 0; j < 33 && j < w2_ch.size(); j++)
            chk("w2_temp_ch_seq", w2_ch[j], j % 32);
        chk("w2_temp_ch_after", int'(ch_o[2]), 1);

        clr();
        sr = cyc;
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        step(2 * P + 3);
        chk("w4_req_before_reset", int'(req_o[1]), 1);
        rst = 1'b0;
        #1;
        chk("reset_req_drop", int'(req_o[1]), 0);
        chk("reset_busy_drop", int'(busy_o[1]), 0);
        step(3);
        rst = 1'b1;
        step(100);
        chk("reset_no_frame_done", fd_cnt[1], 0);
        chk("reset_temp_ch", int'(ch_o[1]), 0);
        clr();
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        step(80);
        chk("restart_first_addr", first_wa[1], 0);
        chk("restart_wr_en_count", we_cnt[1], 4);
        chk("restart_frame_count", fd_cnt[1], 1);
        chk("restart_temp_ch", int'(ch_o[1]), 1);
        if (sr < 0) chk("cycle_counter", sr, 0);

        for (int n = 0; n < 800; n++) begin
            start[1] = ($urandom_range(0, 7) == 0);
            start[2] = ($urandom_range(0, 7) == 0);
            step(1);
        end
        start[1] = 1'b0;
        start[2] = 1'b0;
        step(80);
        chk("random_end_idle", int'(busy_o[1]) + int'(busy_o[2]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
